phaser_out_tap_ctrl: RTL and testbench

Sequencer that owns the delay-control port of one PHASER_OUT_PHY.
- Accepts tap-adjust, counter-load and counter-read commands from the calibration logic over a valid/ready handshake.
- Drives the phaser's COARSE*/FINE*/COUNTER* controls with single-cycle pulses and enforces settle time between steps.
- Shadows the current coarse/fine tap positions and reports completion, errors and read data.

---
 rtl/phaser_out_tap_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_phaser_out_tap_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phaser_out_tap_ctrl.sv
// -----------------------------------------------------------------------------
// phaser_out_tap_ctrl
//
// Sequencer that owns the delay-control port of one PHASER_OUT_PHY. Accepts
// one tap-step / counter-load / counter-read command at a time, turns it into
// single-cycle phaser control pulses separated by settle time, shadows the
// current coarse/fine tap positions and reports completion.
//
// Ports:
//   SYSCLK, RST_N            control clock, synchronous active-low reset
//   CMD_VALID/CMD_READY      command handshake (READY high only while idle)
//   CMD_OP                   00 fine step, 01 coarse step, 10 load, 11 read
//   CMD_INC, CMD_COUNT       step direction and number of steps (0 = no-op)
//   CMD_LOADVAL              counter value for the load op
//   RSP_VALID/ERR/DATA       one-cycle completion pulse, error, read data
//   FINE_TAP, COARSE_TAP     shadow tap positions
//   FINE*/COARSE*/COUNTER*   phaser delay-control port
//   *OVERFLOW, COUNTERREADVAL phaser status inputs
// -----------------------------------------------------------------------------
module phaser_out_tap_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int READ_LAT      = 2,
    parameter int MAX_TAP       = 63,
    parameter int FINE_INIT     = 0,
    parameter int COARSE_INIT   = 0
) (
    input  logic       SYSCLK,
    input  logic       RST_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic       CMD_INC,
    input  logic [5:0] CMD_COUNT,
    input  logic [8:0] CMD_LOADVAL,
    output logic       RSP_VALID,
    output logic       RSP_ERR,
    output logic [8:0] RSP_DATA,
    output logic [5:0] FINE_TAP,
    output logic [5:0] COARSE_TAP,
    output logic       FINEENABLE,
    output logic       FINEINC,
    output logic       COARSEENABLE,
    output logic       COARSEINC,
    output logic       COUNTERLOADEN,
    output logic [8:0] COUNTERLOADVAL,
    output logic       COUNTERREADEN,
    input  logic [8:0] COUNTERREADVAL,
    input  logic       FINEOVERFLOW,
    input  logic       COARSEOVERFLOW
);

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE, S_WAIT, S_LOAD, S_RD_PULSE, S_RD_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] OP_FINE   = 2'd0;
    localparam logic [1:0] OP_COARSE = 2'd1;
    localparam logic [1:0] OP_LOAD   = 2'd2;

    localparam logic [5:0] MAX_TAP6    = 6'(MAX_TAP);
    localparam logic [8:0] MAX_TAP9    = 9'(MAX_TAP);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] READ_LAST   = 8'(READ_LAT - 1);

    state_t     r_state;
    logic [1:0] r_op;
    logic       r_inc;
    logic [5:0] r_steps_left;
    logic [8:0] r_loadval;
    logic [7:0] r_cnt;

    state_t     w_next_state;
    logic       w_done_err;
    logic [1:0] w_op;
    logic       w_inc;
    logic [5:0] w_tap;
    logic       w_at_limit;
    logic       w_overflow;
    logic       w_fine_en, w_fine_inc, w_coarse_en, w_coarse_inc;
    logic       w_load_en, w_read_en;
    logic [8:0] w_load_val;

    // While idle the command has not been latched yet, so the boundary check
    // for the first step looks at the live command fields.
    assign w_op       = (r_state == S_IDLE) ? CMD_OP  : r_op;
    assign w_inc      = (r_state == S_IDLE) ? CMD_INC : r_inc;
    assign w_tap      = (w_op == OP_COARSE) ? COARSE_TAP : FINE_TAP;
    assign w_at_limit = w_inc ? (w_tap == MAX_TAP6) : (w_tap == 6'd0);
    assign w_overflow = (r_op == OP_COARSE) ? COARSEOVERFLOW : FINEOVERFLOW;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge SYSCLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    // NOTE: defaults at the top keep every path assigned, so no latches.
    always_comb begin
        w_next_state = r_state;
        w_done_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    case (CMD_OP)
                        OP_FINE, OP_COARSE: begin
                            if (CMD_COUNT == 6'd0) begin
                                w_next_state = S_DONE;
                            end else if (w_at_limit) begin
                                w_next_state = S_DONE;
                                w_done_err   = 1'b1;
                            end else begin
                                w_next_state = S_PULSE;
                            end
                        end
                        OP_LOAD: begin
                            if (CMD_LOADVAL > MAX_TAP9) begin
                                w_next_state = S_DONE;
                                w_done_err   = 1'b1;
                            end else begin
                                w_next_state = S_LOAD;
                            end
                        end
                        default: w_next_state = S_RD_PULSE;
                    endcase
                end
            end
            S_PULSE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_overflow) begin
                    w_next_state = S_DONE;
                    w_done_err   = 1'b1;
                end else if (r_cnt == SETTLE_LAST) begin
                    if (r_steps_left == 6'd0) begin
                        w_next_state = S_DONE;
                    end else if (w_at_limit) begin
                        w_next_state = S_DONE;
                        w_done_err   = 1'b1;
                    end else begin
                        w_next_state = S_PULSE;
                    end
                end
            end
            S_LOAD:     w_next_state = S_DONE;
            S_RD_PULSE: w_next_state = S_RD_WAIT;
            S_RD_WAIT:  if (r_cnt == READ_LAST) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        w_fine_en    = (w_next_state == S_PULSE) && (w_op == OP_FINE);
        w_coarse_en  = (w_next_state == S_PULSE) && (w_op == OP_COARSE);
        w_fine_inc   = w_fine_en && w_inc;
        w_coarse_inc = w_coarse_en && w_inc;
        w_load_en    = (w_next_state == S_LOAD);
        w_read_en    = (w_next_state == S_RD_PULSE);
        w_load_val   = 9'd0;
        if (w_load_en) w_load_val = (r_state == S_IDLE) ? CMD_LOADVAL : r_loadval;
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            CMD_READY      <= 1'b1;
            FINEENABLE     <= 1'b0;
            FINEINC        <= 1'b0;
            COARSEENABLE   <= 1'b0;
            COARSEINC      <= 1'b0;
            COUNTERLOADEN  <= 1'b0;
            COUNTERLOADVAL <= 9'd0;
            COUNTERREADEN  <= 1'b0;
            RSP_VALID      <= 1'b0;
            RSP_ERR        <= 1'b0;
            RSP_DATA       <= 9'd0;
        end else begin
            CMD_READY      <= (w_next_state == S_IDLE);
            FINEENABLE     <= w_fine_en;
            FINEINC        <= w_fine_inc;
            COARSEENABLE   <= w_coarse_en;
            COARSEINC      <= w_coarse_inc;
            COUNTERLOADEN  <= w_load_en;
            COUNTERLOADVAL <= w_load_val;
            COUNTERREADEN  <= w_read_en;
            RSP_VALID      <= (w_next_state == S_DONE);
            RSP_ERR        <= (w_next_state == S_DONE) && w_done_err;
            // Read data is taken on the edge that closes the last RD_WAIT
            // cycle; every other completion clears it. Held between DONEs.
            if (w_next_state == S_DONE)
                RSP_DATA <= (r_state == S_RD_WAIT) ? COUNTERREADVAL : 9'd0;
        end
    end

    // Command latch, step/settle counters and tap shadows
    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            r_op         <= 2'd0;
            r_inc        <= 1'b0;
            r_steps_left <= 6'd0;
            r_loadval    <= 9'd0;
            r_cnt        <= 8'd0;
            FINE_TAP     <= 6'(FINE_INIT);
            COARSE_TAP   <= 6'(COARSE_INIT);
        end else begin
            if (r_state == S_IDLE && CMD_VALID && CMD_READY) begin
                r_op         <= CMD_OP;
                r_inc        <= CMD_INC;
                r_steps_left <= CMD_COUNT;
                r_loadval    <= CMD_LOADVAL;
            end
            // Counts cycles spent in WAIT / RD_WAIT; zero on entry.
            r_cnt <= (r_state == S_WAIT || r_state == S_RD_WAIT) ? r_cnt + 8'd1 : 8'd0;
            if (r_state == S_PULSE) begin
                r_steps_left <= r_steps_left - 6'd1;
                if (r_op == OP_COARSE)
                    COARSE_TAP <= r_inc ? COARSE_TAP + 6'd1 : COARSE_TAP - 6'd1;
                else
                    FINE_TAP <= r_inc ? FINE_TAP + 6'd1 : FINE_TAP - 6'd1;
            end
            if (r_state == S_LOAD) COARSE_TAP <= r_loadval[5:0];
        end
    end

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phaser_out_tap_ctrl
//
// Scoreboarded bench: the driver issues commands, predicts each response from
// a command-level model of tap positions and timing, and pushes it into a
// queue; the monitor watches the phaser pulses and pops/compares on RSP_VALID.
// Cycle k of a command is the k-th cycle after its accept edge.
// -----------------------------------------------------------------------------
module tb_phaser_out_tap_ctrl;

    localparam int S    = 8;
    localparam int L    = 2;
    localparam int MAXT = 63;
    localparam int FI   = 0;
    localparam int CI   = 0;

    logic       SYSCLK = 1'b0;
    logic       RST_N  = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_OP = 2'd0;
    logic       CMD_INC = 1'b0;
    logic [5:0] CMD_COUNT = 6'd0;
    logic [8:0] CMD_LOADVAL = 9'd0;
    logic       RSP_VALID, RSP_ERR;
    logic [8:0] RSP_DATA;
    logic [5:0] FINE_TAP, COARSE_TAP;
    logic       FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
    logic       COUNTERLOADEN, COUNTERREADEN;
    logic [8:0] COUNTERLOADVAL;
    logic [8:0] COUNTERREADVAL = 9'd0;
    logic       FINEOVERFLOW = 1'b0;
    logic       COARSEOVERFLOW = 1'b0;

    phaser_out_tap_ctrl #(
        .SETTLE_CYCLES(S), .READ_LAT(L), .MAX_TAP(MAXT),
        .FINE_INIT(FI), .COARSE_INIT(CI)
    ) dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_INC(CMD_INC), .CMD_COUNT(CMD_COUNT), .CMD_LOADVAL(CMD_LOADVAL),
        .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_DATA(RSP_DATA),
        .FINE_TAP(FINE_TAP), .COARSE_TAP(COARSE_TAP),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
        .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL),
        .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    typedef struct {
        int         base;
        int         lat;
        logic       err;
        logic [8:0] data;
        int         fine;
        int         coarse;
        int         nf, nc, nl, nr, np;
        logic       inc;
        logic [8:0] lval;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_fine   = FI;
    int   m_coarse = CI;
    logic rd_fixed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [8:0] rd_pattern(input int c);
        logic [31:0] v;
        v = 32'(c) * 32'd149 + 32'd71;
        return v[8:0];
    endfunction

    // Phaser counter value changes every cycle so a capture on the wrong
    // cycle shows up as wrong read data.
    always @(posedge SYSCLK) begin
        #1;
        if (!rd_fixed) COUNTERREADVAL = rd_pattern(cyc);
    end

    // ---------------- monitor ----------------
    int nf_s, nc_s, nl_s, nr_s, ninc_s, first_s, last_s, en_sum;
    logic [8:0] lval_s;

    task automatic mon_clear();
        nf_s = 0; nc_s = 0; nl_s = 0; nr_s = 0; ninc_s = 0;
        first_s = -1000; last_s = -1000; lval_s = 9'd0;
    endtask

    initial mon_clear();

    always @(negedge SYSCLK) begin
        if (!RST_N) begin
            mon_clear();
        end else begin
            en_sum = int'(FINEENABLE) + int'(COARSEENABLE) + int'(COUNTERLOADEN) + int'(COUNTERREADEN);
            if (en_sum != 0) check("one_enable_at_a_time", en_sum, 1);
            if ((FINEINC && !FINEENABLE) || (COARSEINC && !COARSEENABLE))
                check("inc_without_enable", 1, 0);
            if (FINEENABLE || COARSEENABLE) begin
                if (first_s == -1000) first_s = cyc;
                last_s = cyc;
            end
            if (FINEENABLE)    nf_s++;
            if (COARSEENABLE)  nc_s++;
            if (FINEINC || COARSEINC) ninc_s++;
            if (COUNTERLOADEN) begin nl_s++; lval_s = COUNTERLOADVAL; end
            if (COUNTERREADEN) nr_s++;
            if (RSP_VALID) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_latency", cyc - e.base, e.lat);
                    check("rsp_err", RSP_ERR, e.err);
                    check("rsp_data", RSP_DATA, e.data);
                    check("fine_tap", FINE_TAP, e.fine);
                    check("coarse_tap", COARSE_TAP, e.coarse);
                    check("fine_pulses", nf_s, e.nf);
                    check("coarse_pulses", nc_s, e.nc);
                    check("load_pulses", nl_s, e.nl);
                    check("read_pulses", nr_s, e.nr);
                    check("inc_pulses", ninc_s, e.inc ? e.np : 0);
                    if (e.np > 0) begin
                        check("first_pulse_cycle", first_s - e.base, 1);
                        check("last_pulse_cycle", last_s - e.base, 1 + (e.np - 1) * (1 + S));
                    end
                    if (e.nl > 0) check("load_value", lval_s, e.lval);
                end
                mon_clear();
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!CMD_READY && w < 3000) begin tick(); w++; end
        if (w >= 3000) check("ready_timeout", 0, 1);
    endtask

    task automatic check_reset_state();
        check("rst_cmd_ready", CMD_READY, 1);
        check("rst_fineenable", FINEENABLE, 0);
        check("rst_fineinc", FINEINC, 0);
        check("rst_coarseenable", COARSEENABLE, 0);
        check("rst_coarseinc", COARSEINC, 0);
        check("rst_loaden", COUNTERLOADEN, 0);
        check("rst_loadval", COUNTERLOADVAL, 0);
        check("rst_readen", COUNTERREADEN, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_err", RSP_ERR, 0);
        check("rst_rsp_data", RSP_DATA, 0);
        check("rst_fine_tap", FINE_TAP, FI);
        check("rst_coarse_tap", COARSE_TAP, CI);
    endtask

    // ovs < 0: no overflow. Otherwise overflow is raised in WAIT cycle ovo
    // (1-based) after step ovs (0-based), on the matching line when ovm=1.
    task automatic issue(input logic [1:0] op, input logic inc, input logic [5:0] cnt,
                         input logic [8:0] lv, input int ovs, input int ovo, input logic ovm,
                         input logic fixrd, input logic [8:0] rdv);
        exp_t e;
        int   base, t, tcyc;
        wait_ready();
        rd_fixed = fixrd;
        if (fixrd) COUNTERREADVAL = rdv;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_INC = inc; CMD_COUNT = cnt; CMD_LOADVAL = lv;
        tick();
        base = cyc - 1;
        e = '{base: base, lat: 0, err: 1'b0, data: 9'd0, fine: 0, coarse: 0,
              nf: 0, nc: 0, nl: 0, nr: 0, np: 0, inc: 1'b0, lval: 9'd0};
        if (op <= 2'd1) begin
            t     = (op == 2'd1) ? m_coarse : m_fine;
            e.inc = inc;
            e.lat = 1 + int'(cnt) * (1 + S);
            for (int i = 0; i < int'(cnt); i++) begin
                if (inc ? (t == MAXT) : (t == 0)) begin
                    e.err = 1'b1; e.lat = 1 + i * (1 + S); break;
                end
                t += inc ? 1 : -1;
                e.np++;
                if (ovm && ovs == i) begin
                    e.err = 1'b1; e.lat = 2 + i * (1 + S) + ovo; break;
                end
            end
            if (op == 2'd1) begin m_coarse = t; e.nc = e.np; end
            else            begin m_fine = t;   e.nf = e.np; end
        end else if (op == 2'd2) begin
            if (int'(lv) > MAXT) begin
                e.err = 1'b1; e.lat = 1;
            end else begin
                e.lat = 2; m_coarse = int'(lv); e.nl = 1; e.lval = lv;
            end
        end else begin
            e.lat = 2 + L; e.nr = 1;
            e.data = fixrd ? rdv : rd_pattern(base + 1 + L);
        end
        e.fine = m_fine; e.coarse = m_coarse;
        sbq.push_back(e);
        check("ready_low_when_busy", CMD_READY, 0);
        // Scrambled request held over the first busy cycle must be ignored.
        CMD_OP = 2'($urandom); CMD_INC = 1'($urandom);
        CMD_COUNT = 6'($urandom); CMD_LOADVAL = 9'($urandom);
        tick();
        CMD_VALID = 1'b0;
        if (ovs >= 0) begin
            tcyc = base + 1 + ovs * (1 + S) + ovo;
            while (cyc < tcyc) tick();
            if ((op == 2'd1) == ovm) COARSEOVERFLOW = 1'b1;
            else                     FINEOVERFLOW   = 1'b1;
            tick();
            FINEOVERFLOW = 1'b0; COARSEOVERFLOW = 1'b0;
        end
    endtask

    initial begin
        int base;
        logic [1:0] op;
        logic [5:0] cnt;
        logic [8:0] lv;
        int ovs, ovo;
        logic ovm;

        repeat (3) tick();
        RST_N = 1'b1;
        check_reset_state();
        tick();

        // Directed cases
        issue(2'd0, 1'b1, 6'd3, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);    // fine +3
        issue(2'd2, 1'b0, 6'd0, 9'd62, -1, 0, 1'b0, 1'b0, 9'd0);   // coarse=62
        issue(2'd1, 1'b1, 6'd4, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);    // hits 63
        issue(2'd0, 1'b1, 6'd2, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);    // fine=5
        issue(2'd0, 1'b0, 6'd5, 9'd0, 1, 3, 1'b1, 1'b0, 9'd0);     // overflow
        issue(2'd0, 1'b0, 6'd0, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);    // N=0
        issue(2'd0, 1'b0, 6'd9, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);    // hits 0
        issue(2'd2, 1'b0, 6'd0, 9'd40, -1, 0, 1'b0, 1'b0, 9'd0);
        issue(2'd2, 1'b0, 6'd0, 9'd100, -1, 0, 1'b0, 1'b0, 9'd0);
        issue(2'd3, 1'b0, 6'd0, 9'd0, -1, 0, 1'b0, 1'b1, 9'h1A5);
        issue(2'd3, 1'b0, 6'd0, 9'd0, -1, 0, 1'b0, 1'b0, 9'd0);

        // Reset during the 2nd WAIT of a 4-step command: no response expected
        wait_ready();
        CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_INC = 1'b1; CMD_COUNT = 6'd4;
        tick();
        base = cyc - 1;
        CMD_VALID = 1'b0;
        while (cyc < base + 13) tick();
        RST_N = 1'b0;
        tick();
        check_reset_state();
        m_fine = FI; m_coarse = CI;
        tick();
        RST_N = 1'b1;
        repeat (3) begin
            tick();
            check("ready_after_reset", CMD_READY, 1);
        end

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            op  = 2'($urandom_range(0, 3));
            cnt = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) cnt = 6'($urandom_range(8, 63));
            lv  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 63)) : 9'($urandom_range(0, 511));
            ovs = -1; ovo = 0; ovm = 1'b0;
            if (op <= 2'd1 && cnt != 6'd0 && $urandom_range(0, 3) == 0) begin
                ovs = $urandom_range(0, int'(cnt) - 1);
                ovo = $urandom_range(1, S);
                ovm = 1'($urandom);
            end
            issue(op, 1'($urandom), cnt, lv, ovs, ovo, ovm, 1'b0, 9'd0);
        end

        wait_ready();
        repeat (4) tick();
        check("pending_responses", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
